// File: rtl/pipeline_demo_pkg.sv
// Shared definitions for the demo sequencer: FSM state encoding and the
// rule that maps a test-vector index to its expected detector label.
package pipeline_demo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHOW  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_e;

    // Even-numbered vectors carry a seizure pattern, odd-numbered ones do not.
    function automatic logic expected_seizure(input logic [31:0] index);
        return ((index & 32'd1) == 32'd0);
    endfunction

endpackage

// File: rtl/pipeline_demo_sequencer_btn_sync_edge.sv
// Multi-stage synchroniser for the raw start button followed by a rising-edge
// detector on the two oldest stages, giving a single-cycle pulse per press.
module btn_sync_edge #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw button into the youngest stage; stage 0 is the youngest.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], btn_i};
    end

    // Synchroniser flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Rising edge: the newer of the last two stages is high, the older still low.
    assign pulse_o = sync_q[STAGES-2] & ~sync_q[STAGES-1];

endmodule

// File: rtl/pipeline_demo_sequencer.sv
// Demo sequencer that feeds test-vector indices to a seizure detector, either
// one manually selected vector or an automatic sweep of all vectors, scores
// each detector answer against the expected label and drives status LEDs.
module pipeline_demo_sequencer
    import pipeline_demo_pkg::*;
#(
    parameter int N_VECTORS      = 10,
    parameter int IDX_W          = 4,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] vector_sel,
    input  logic             start_btn,
    input  logic             mode_auto,
    input  logic             det_ready,
    input  logic             det_result_valid,
    input  logic             det_seizure,
    output logic             det_start,
    output logic [IDX_W-1:0] det_index,
    output logic             seizure_led,
    output logic             non_seizure_led,
    output logic             processing_led,
    output logic             ready_led,
    output logic             error_led,
    output logic             sweep_done,
    output logic [IDX_W-1:0] vector_leds,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count
);

    localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_VECTORS - 1);
    localparam logic [IDX_W:0]   N_VEC_EXT = (IDX_W + 1)'(N_VECTORS);

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_W'(1));
    endfunction

    seq_state_e       state_q, state_d;
    logic             start_pulse_s;
    logic [IDX_W-1:0] sel_meta_q, sel_sync_q, sel_clamped_s;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             res_q, res_d;
    logic             res_valid_q, res_valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             timeout_s;
    logic             seizure_led_q, non_seizure_led_q, processing_led_q;
    logic             ready_led_q, error_led_q, sweep_done_q;
    logic [IDX_W-1:0] vector_leds_q;

    btn_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (start_btn),
        .pulse_o (start_pulse_s)
    );

    // Two-flop synchroniser for the vector selection switches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_meta_q <= '0;
            sel_sync_q <= '0;
        end else begin
            sel_meta_q <= vector_sel;
            sel_sync_q <= sel_meta_q;
        end
    end

    // Clamp out-of-range selections to the last valid vector.
    always_comb begin
        if ({1'b0, sel_sync_q} >= N_VEC_EXT) begin
            sel_clamped_s = LAST_IDX;
        end else begin
            sel_clamped_s = sel_sync_q;
        end
    end

    assign timeout_s = (tmo_q == TMO_LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse_s && det_ready) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (det_result_valid || timeout_s) begin
                    state_d = mode_q ? ST_NEXT : ST_SHOW;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SHOW: state_d = ST_IDLE;
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else if (det_ready) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the sequencing fields and counters.
    always_comb begin
        idx_d       = idx_q;
        mode_d      = mode_q;
        tmo_d       = tmo_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        err_d       = err_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse_s && det_ready) begin
                    mode_d      = mode_auto;
                    res_valid_d = 1'b0;
                    if (mode_auto) begin
                        idx_d  = '0;
                        pass_d = '0;
                        fail_d = '0;
                        err_d  = 1'b0;
                    end else begin
                        idx_d = sel_clamped_s;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_ISSUE: tmo_d = '0;
            ST_WAIT: begin
                // A result in the same cycle as the timeout wins.
                if (det_result_valid) begin
                    res_d       = det_seizure;
                    res_valid_d = 1'b1;
                    if (det_seizure == expected_seizure(32'(idx_q))) begin
                        pass_d = sat_inc(pass_q);
                    end else begin
                        fail_d = sat_inc(fail_q);
                    end
                end else if (timeout_s) begin
                    err_d       = 1'b1;
                    fail_d      = sat_inc(fail_q);
                    res_valid_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_NEXT: begin
                if ((idx_q != LAST_IDX) && det_ready) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    idx_d = idx_q;
                end
            end
            default: idx_d = idx_q;
        endcase
    end

    // Sequencing fields and score counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            mode_q      <= 1'b0;
            tmo_q       <= '0;
            res_q       <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
        end else begin
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            tmo_q       <= tmo_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    // Status LEDs registered from the current state, lagging it by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seizure_led_q     <= 1'b0;
            non_seizure_led_q <= 1'b0;
            processing_led_q  <= 1'b0;
            ready_led_q       <= 1'b0;
            error_led_q       <= 1'b0;
            sweep_done_q      <= 1'b0;
            vector_leds_q     <= '0;
        end else begin
            seizure_led_q     <= res_valid_q & res_q;
            non_seizure_led_q <= res_valid_q & ~res_q;
            processing_led_q  <= (state_q == ST_ISSUE) || (state_q == ST_WAIT) ||
                                 (state_q == ST_NEXT);
            ready_led_q       <= (state_q == ST_IDLE) && det_ready;
            error_led_q       <= err_q;
            sweep_done_q      <= (state_q == ST_DONE);
            vector_leds_q     <= (state_q == ST_IDLE) ? sel_clamped_s : idx_q;
        end
    end

    // The detector handshake comes straight from state so it has no extra lag.
    assign det_start       = (state_q == ST_ISSUE);
    assign det_index       = idx_q;
    assign seizure_led     = seizure_led_q;
    assign non_seizure_led = non_seizure_led_q;
    assign processing_led  = processing_led_q;
    assign ready_led       = ready_led_q;
    assign error_led       = error_led_q;
    assign sweep_done      = sweep_done_q;
    assign vector_leds     = vector_leds_q;
    assign pass_count      = pass_q;
    assign fail_count      = fail_q;

endmodule

// File: tb/tb_pipeline_demo_sequencer.sv
// Bench for the demo sequencer. Instance A uses default parameters; instance B
// uses a 16-cycle timeout and 2-bit counters. Shared stimulus is steered to
// the active instance, and its outputs are compared against a label/score
// model built from the vector rules.
module tb_pipeline_demo_sequencer;

    localparam int IDX_W = 4;
    localparam int NV    = 10;
    localparam int A_TMO = 4096;
    localparam int B_TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, start_btn, mode_auto, det_ready;
    logic             det_result_valid, det_seizure, use_b;
    logic [IDX_W-1:0] vector_sel;

    logic a_start_btn, a_valid, b_start_btn, b_valid;
    assign a_start_btn = use_b ? 1'b0 : start_btn;
    assign a_valid     = use_b ? 1'b0 : det_result_valid;
    assign b_start_btn = use_b ? start_btn : 1'b0;
    assign b_valid     = use_b ? det_result_valid : 1'b0;

    logic             a_det_start, a_sz, a_nsz, a_proc, a_rdy, a_err, a_done;
    logic [IDX_W-1:0] a_det_index, a_vleds;
    logic [7:0]       a_pass, a_fail;
    logic             b_det_start, b_sz, b_nsz, b_proc, b_rdy, b_err, b_done;
    logic [IDX_W-1:0] b_det_index, b_vleds;
    logic [1:0]       b_pass, b_fail;

    pipeline_demo_sequencer u_dut_a (
        .clk(clk), .rst_n(rst_n), .vector_sel(vector_sel), .start_btn(a_start_btn),
        .mode_auto(mode_auto), .det_ready(det_ready), .det_result_valid(a_valid),
        .det_seizure(det_seizure), .det_start(a_det_start), .det_index(a_det_index),
        .seizure_led(a_sz), .non_seizure_led(a_nsz), .processing_led(a_proc),
        .ready_led(a_rdy), .error_led(a_err), .sweep_done(a_done),
        .vector_leds(a_vleds), .pass_count(a_pass), .fail_count(a_fail)
    );

    pipeline_demo_sequencer #(.TIMEOUT_CYCLES(B_TMO), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .vector_sel(vector_sel), .start_btn(b_start_btn),
        .mode_auto(mode_auto), .det_ready(det_ready), .det_result_valid(b_valid),
        .det_seizure(det_seizure), .det_start(b_det_start), .det_index(b_det_index),
        .seizure_led(b_sz), .non_seizure_led(b_nsz), .processing_led(b_proc),
        .ready_led(b_rdy), .error_led(b_err), .sweep_done(b_done),
        .vector_leds(b_vleds), .pass_count(b_pass), .fail_count(b_fail)
    );

    logic             o_det_start, o_sz, o_nsz, o_proc, o_rdy, o_err, o_done;
    logic [IDX_W-1:0] o_det_index, o_vleds;
    logic [7:0]       o_pass, o_fail;
    logic [31:0]      o_all;
    assign o_det_start = use_b ? b_det_start : a_det_start;
    assign o_det_index = use_b ? b_det_index : a_det_index;
    assign o_sz        = use_b ? b_sz : a_sz;
    assign o_nsz       = use_b ? b_nsz : a_nsz;
    assign o_proc      = use_b ? b_proc : a_proc;
    assign o_rdy       = use_b ? b_rdy : a_rdy;
    assign o_err       = use_b ? b_err : a_err;
    assign o_done      = use_b ? b_done : a_done;
    assign o_vleds     = use_b ? b_vleds : a_vleds;
    assign o_pass      = use_b ? {6'd0, b_pass} : a_pass;
    assign o_fail      = use_b ? {6'd0, b_fail} : a_fail;
    assign o_all = {1'b0, o_det_start, o_det_index, o_sz, o_nsz, o_proc, o_rdy,
                    o_err, o_done, o_vleds, o_pass, o_fail};

    int vectors = 0;
    int miscompares = 0;
    int n_start = 0;
    int n_done = 0;
    int exp_pass = 0;
    int exp_fail = 0;
    int exp_err = 0;
    int cnt_max = 255;

    // Count detector requests and sweep-done pulses of the active instance.
    always @(posedge clk) begin
        if (o_det_start === 1'b1) n_start <= n_start + 1;
        if (o_done === 1'b1) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= cnt_max) ? cnt_max : v + 1;
    endfunction

    // Score one detector answer the way the demo rules define it.
    task automatic score(input int idx, input bit seiz);
        if (seiz == ((idx % 2) == 0)) exp_pass = sat(exp_pass);
        else exp_fail = sat(exp_fail);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic press();
        start_btn = 1'b1;
        step();
        step();
        start_btn = 1'b0;
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            if (o_det_start === 1'b1) seen = 1'b1;
        end
        check("det_start_seen", 32'(seen), 32'd1);
    endtask

    // Called in the request cycle; answers in the delay-th wait cycle.
    task automatic respond(input int delay, input bit seiz, input int idx);
        step();
        check("processing_led", 32'(o_proc), 32'd1);
        check("vector_leds_busy", 32'(o_vleds), 32'(idx));
        check("det_index_hold", 32'(o_det_index), 32'(idx));
        repeat (delay - 1) step();
        det_result_valid = 1'b1;
        det_seizure = seiz;
        step();
        det_result_valid = 1'b0;
        det_seizure = 1'b0;
        score(idx, seiz);
    endtask

    task automatic manual_run(input int sel, input int delay, input bit seiz);
        int idx;
        int s0;
        bit seen;
        idx = (sel >= NV) ? NV - 1 : sel;
        mode_auto = 1'b0;
        vector_sel = 4'(sel);
        repeat (4) step();
        check("vector_leds_idle", 32'(o_vleds), 32'(idx));
        s0 = n_start;
        press();
        wait_start(seen);
        if (seen) begin
            check("det_index", 32'(o_det_index), 32'(idx));
            respond(delay, seiz, idx);
            repeat (2) step();
            check("seizure_led", 32'(o_sz), 32'(seiz));
            check("non_seizure_led", 32'(o_nsz), 32'(!seiz));
            check("pass_count", 32'(o_pass), 32'(exp_pass));
            check("fail_count", 32'(o_fail), 32'(exp_fail));
            check("error_led", 32'(o_err), 32'(exp_err));
            check("ready_led_after", 32'(o_rdy), 32'd1);
            check("det_start_once", 32'(n_start - s0), 32'd1);
        end
    endtask

    initial begin
        bit seen;
        int s0;
        int d0;
        use_b = 1'b0; rst_n = 1'b0; start_btn = 1'b0; mode_auto = 1'b0;
        det_ready = 1'b1; det_result_valid = 1'b0; det_seizure = 1'b0;
        vector_sel = 4'd0;
        repeat (3) step();
        check("reset_outputs", o_all, 32'd0);
        rst_n = 1'b1;
        repeat (4) step();

        // Manual hit, manual miss, clamped selection.
        manual_run(4, 20, 1'b1);
        manual_run(3, 5, 1'b1);
        manual_run(15, 7, 1'b0);
        // Randomised manual runs.
        for (int r = 0; r < 6; r++) begin
            manual_run(int'($urandom_range(15, 0)), int'($urandom_range(40, 1)),
                       1'($urandom_range(1, 0)));
        end

        // Start while the detector is busy is ignored.
        det_ready = 1'b0;
        s0 = n_start;
        press();
        repeat (10) step();
        check("no_start_not_ready", 32'(n_start - s0), 32'd0);
        check("ready_led_low", 32'(o_rdy), 32'd0);
        det_ready = 1'b1;
        repeat (2) step();
        check("ready_led_high", 32'(o_rdy), 32'd1);

        // Automatic sweep with an ideal detector and random ready gaps.
        mode_auto = 1'b1;
        s0 = n_start;
        d0 = n_done;
        press();
        exp_pass = 0; exp_fail = 0; exp_err = 0;
        for (int k = 0; k < NV; k++) begin
            wait_start(seen);
            if (seen) begin
                check("sweep_index", 32'(o_det_index), 32'(k));
                respond(int'($urandom_range(10, 1)), ((k % 2) == 0), k);
                if (k < NV - 1) begin
                    det_ready = 1'b0;
                    repeat (int'($urandom_range(4, 0))) step();
                    det_ready = 1'b1;
                end
            end
        end
        mode_auto = 1'b0;
        repeat (5) step();
        check("sweep_starts", 32'(n_start - s0), 32'(NV));
        check("sweep_done_once", 32'(n_done - d0), 32'd1);
        check("sweep_pass", 32'(o_pass), 32'(exp_pass));
        check("sweep_fail", 32'(o_fail), 32'd0);
        check("sweep_pass_ten", 32'(exp_pass), 32'd10);

        // Result arriving in the final allowed wait cycle beats the timeout.
        manual_run(2, A_TMO, 1'b1);

        // Reset in the middle of a sweep.
        mode_auto = 1'b1;
        d0 = n_done;
        press();
        exp_pass = 0; exp_fail = 0; exp_err = 0;
        wait_start(seen);
        if (seen) respond(3, 1'b1, 0);
        wait_start(seen);
        step();
        rst_n = 1'b0;
        mode_auto = 1'b0;
        repeat (2) step();
        check("reset_mid_sweep", o_all, 32'd0);
        rst_n = 1'b1;
        s0 = n_start;
        step();
        det_result_valid = 1'b1;
        det_seizure = 1'b1;
        step();
        det_result_valid = 1'b0;
        det_seizure = 1'b0;
        repeat (6) step();
        exp_pass = 0; exp_fail = 0; exp_err = 0;
        check("post_reset_pass", 32'(o_pass), 32'd0);
        check("post_reset_fail", 32'(o_fail), 32'd0);
        check("post_reset_sz", 32'(o_sz), 32'd0);
        check("post_reset_no_done", 32'(n_done - d0), 32'd0);
        check("post_reset_no_start", 32'(n_start - s0), 32'd0);
        check("post_reset_ready", 32'(o_rdy), 32'd1);

        // Instance B: short timeout and 2-bit saturating counters.
        use_b = 1'b1;
        cnt_max = 3;
        exp_pass = 0; exp_fail = 0; exp_err = 0;
        repeat (3) step();
        manual_run(4, 5, 1'b1);
        vector_sel = 4'd1;
        repeat (4) step();
        press();
        wait_start(seen);
        repeat (B_TMO) step();
        check("timeout_not_early", 32'(o_fail), 32'(exp_fail));
        repeat (3) step();
        exp_fail = sat(exp_fail);
        exp_err = 1;
        check("timeout_fail", 32'(o_fail), 32'(exp_fail));
        check("timeout_error_led", 32'(o_err), 32'd1);
        check("timeout_sz_clear", 32'(o_sz), 32'd0);
        check("timeout_nsz_clear", 32'(o_nsz), 32'd0);
        check("timeout_idle", 32'(o_rdy), 32'd1);
        manual_run(0, 3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            manual_run(i, int'($urandom_range(10, 1)), ((i % 2) == 1));
        end
        check("fail_saturated", 32'(o_fail), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_demo_sequencer.md
PIPELINE_DEMO_SEQUENCER -- requirements
Module: pipeline_demo_sequencer

Interface
REQ-001 The block SHALL have parameter N_VECTORS, default 10: number of test vectors, legal 2..2**IDX_W.
REQ-002 The block SHALL have parameter IDX_W, default 4: vector index width.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 3: start-button synchroniser depth, minimum 2.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum wait for a detector result.
REQ-005 The block SHALL have parameter CNT_W, default 8: width of the pass and fail counters.
REQ-006 Ports SHALL be: clk in 1 clock; rst_n in 1 reset, synchronous active-low (one clock, sampled on posedge clk only).
REQ-007 Ports SHALL be: vector_sel in IDX_W, switch selection; start_btn in 1, raw button; mode_auto in 1, 1 = sweep all vectors.
REQ-008 Ports SHALL be: det_ready in 1; det_result_valid in 1; det_seizure in 1 (all from the detector).
REQ-009 Ports SHALL be: det_start out 1, single-cycle classify request; det_index out IDX_W, vector for the pattern generator.
REQ-010 Ports SHALL be: seizure_led, non_seizure_led, processing_led, ready_led, error_led, sweep_done out 1 each; vector_leds out IDX_W; pass_count and fail_count out CNT_W each.

Function
REQ-011 start_btn SHALL pass through SYNC_STAGES flops, and a rising edge of the last two stages SHALL give a one-cycle start pulse.
REQ-012 vector_sel SHALL be 2-flop synchronised, and values >= N_VECTORS SHALL clamp to N_VECTORS-1.
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, SHOW, NEXT, DONE; the reset state SHALL be IDLE.
REQ-014 IDLE: a start pulse with det_ready=1 SHALL sample mode_auto, latch the index (synced vector_sel if manual, 0 if auto), and go to ISSUE.
REQ-015 Auto start SHALL also clear pass_count, fail_count and error_led.
REQ-016 A start pulse while det_ready=0, or in any state other than IDLE, SHALL be ignored.
REQ-017 ISSUE: det_start SHALL be 1 for exactly one cycle, the timeout counter SHALL clear, and the FSM SHALL go to WAIT.
REQ-018 det_index SHALL hold the latched index, stable from ISSUE until WAIT is left.
REQ-019 WAIT: on det_result_valid=1, the block SHALL latch det_seizure and compare it with the expected label (index[0]==0 is seizure).
REQ-020 On that result, a match SHALL increment pass_count and a mismatch SHALL increment fail_count; both counters SHALL saturate at all-ones.
REQ-021 WAIT: if no result has arrived after TIMEOUT_CYCLES cycles, the block SHALL set error_led, increment fail_count, and clear both result LEDs.
REQ-022 If det_result_valid and the timeout occur in the same cycle, the result SHALL take priority and no timeout SHALL be recorded.
REQ-023 After WAIT, the FSM SHALL go to SHOW if in manual mode and to NEXT if in auto mode.
REQ-024 SHOW SHALL last one cycle, then return to IDLE; result LEDs SHALL hold until the next accepted start.
REQ-025 NEXT: if index==N_VECTORS-1, the FSM SHALL go to DONE.
REQ-026 NEXT: otherwise it SHALL increment the index and go to ISSUE in the first cycle with det_ready=1.
REQ-027 DONE SHALL pulse sweep_done for one cycle, then return to IDLE.
REQ-028 seizure_led SHALL equal the latched result AND valid; non_seizure_led SHALL equal NOT result AND valid.
REQ-029 processing_led SHALL be 1 in ISSUE, WAIT and NEXT.
REQ-030 ready_led SHALL equal (state==IDLE AND det_ready).
REQ-031 vector_leds SHALL equal the latched index while busy, and the synced, clamped selection in IDLE.
REQ-032 All LED outputs, sweep_done and the counters SHALL be registered; LEDs SHALL lag the state by exactly one cycle.
REQ-033 det_start and det_index SHALL be driven directly from registered state, with no extra lag.

Reset
REQ-034 rst_n=0 sampled at a clock edge SHALL put the FSM in IDLE, and all outputs, counters, synchroniser flops and latched fields SHALL become 0.
REQ-035 Reset mid-sweep SHALL abandon the sweep with no sweep_done pulse, and a det_result_valid arriving after reset SHALL be ignored.

Structure
REQ-036 A shared package pipeline_demo_pkg SHALL hold the FSM state enum and the label rule function (expected_seizure(index)).
REQ-037 One sub-module, btn_sync_edge (parameter STAGES), SHALL implement the synchroniser and rising-edge detector.
REQ-038 The implementation SHALL be 120-400 lines of RTL, with no memories and no combinational path from inputs to outputs.

Verification
REQ-039 Manual hit: vector_sel=4, press start, detector answers seizure after 20 cycles -> one det_start with det_index=4; seizure_led=1; pass_count=1.
REQ-040 Manual miss: vector_sel=3, detector answers seizure -> seizure_led=1; fail_count=1; error_led=0.
REQ-041 Auto sweep, N_VECTORS=10, ideal detector -> 10 det_start pulses with indices 0..9; pass_count=10; fail_count=0; sweep_done pulses once.
REQ-042 Timeout, TIMEOUT_CYCLES=16, detector silent -> error_led=1 and fail_count=1 after the wait; FSM back in IDLE; the next start is accepted.
REQ-043 Edge cases: vector_sel=15 gives det_index=9; start with det_ready=0 gives no det_start; result and timeout coincident gives no error; rst_n low mid-sweep gives all outputs 0 and no sweep_done.
REQ-044 Saturation, CNT_W=2: five mismatches -> fail_count=3, with no wrap.
